// File: rtl/irm_pkg.sv
// Shared types and constants for the inference run monitor.
package irm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } state_e;

    localparam int REG_IDX_W  = 5;
    localparam int LAT_CORE_W = 3;

    // Latency FIFO entry layout for the default 32-bit data width.
    typedef struct packed {
        logic [LAT_CORE_W-1:0] core;
        logic [28:0]           lat;
    } lat_entry_t;

endpackage

// File: rtl/irm_core_tracker.sv
// Per-core snooper: holds image/correct shadows and the exit flag, and
// pulses img_evt_o when a new non-zero image index is written.
module irm_core_tracker
    import irm_pkg::*;
#(
    parameter int DWidth   = 32,
    parameter int ExitReg  = 25,
    parameter int ImgReg   = 26,
    parameter int CorrReg  = 27,
    parameter int ExitCode = 99999
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 active_i,
    input  logic                 wb_valid_i,
    input  logic [REG_IDX_W-1:0] wb_rd_i,
    input  logic [DWidth-1:0]    wb_data_i,
    output logic [DWidth-1:0]    corr_o,
    output logic                 exit_o,
    output logic                 exit_set_o,
    output logic                 img_evt_o
);

    logic [DWidth-1:0] img_q, img_d;
    logic [DWidth-1:0] corr_q, corr_d;
    logic              exit_q, exit_d;
    logic              wr;

    // Decode one write-back; an exited core no longer updates anything.
    always_comb begin
        img_d      = img_q;
        corr_d     = corr_q;
        exit_d     = exit_q;
        img_evt_o  = 1'b0;
        exit_set_o = 1'b0;
        wr = active_i && wb_valid_i && (wb_rd_i != '0) && !exit_q;
        if (wr) begin
            if (wb_rd_i == REG_IDX_W'(ImgReg)) begin
                if (wb_data_i != img_q) begin
                    img_d     = wb_data_i;
                    img_evt_o = (wb_data_i != '0);
                end
            end else if (wb_rd_i == REG_IDX_W'(CorrReg)) begin
                corr_d = wb_data_i;
            end else if (wb_rd_i == REG_IDX_W'(ExitReg) && wb_data_i == DWidth'(ExitCode)) begin
                exit_d     = 1'b1;
                exit_set_o = 1'b1;
            end
        end
    end

    // Shadow registers, cleared on reset and on run start.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            img_q  <= '0;
            corr_q <= '0;
            exit_q <= 1'b0;
        end else begin
            img_q  <= img_d;
            corr_q <= corr_d;
            exit_q <= exit_d;
        end
    end

    assign corr_o = corr_q;
    assign exit_o = exit_q;

endmodule

// File: rtl/inference_run_monitor.sv
// Run monitor for NumCores MLP inference cores: FSM, aggregate counters and
// optional per-image latency FIFO (enabled by defining LAT_FIFO_EN).
module inference_run_monitor
    import irm_pkg::*;
#(
    parameter int DWidth        = 32,
    parameter int NumCores      = 1,
    parameter int NumOfTest     = 10,
    parameter int ExitReg       = 25,
    parameter int ImgReg        = 26,
    parameter int CorrReg       = 27,
    parameter int ExitCode      = 99999,
    parameter int TimeoutCycles = 0,
    parameter int LatDepth      = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic [NumCores-1:0]            wb_valid_i,
    input  logic [NumCores*REG_IDX_W-1:0]  wb_rd_i,
    input  logic [NumCores*DWidth-1:0]     wb_data_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           timeout_o,
    output logic [NumCores-1:0]            core_exit_o,
    output logic [DWidth-1:0]              correct_tot_o,
    output logic [DWidth-1:0]              image_tot_o,
    output logic [63:0]                    cycle_o,
    output logic                           lat_valid_o,
    output logic [DWidth-1:0]              lat_data_o,
    input  logic                           lat_ready_i,
    output logic                           lat_ovf_o
);

    state_e state_q, state_d;
    logic   clr, run;
    logic [NumCores-1:0][DWidth-1:0] corr;
    logic [NumCores-1:0] exit_q, exit_set, evt;
    logic [DWidth-1:0]   corr_sum, correct_tot_q, image_tot_q;
    logic [DWidth:0]     img_sum;
    logic [3:0]          n_evt;
    logic [63:0]         cycle_q;

    assign run = (state_q == RUN);
    assign clr = start_i && !run;

    for (genvar c = 0; c < NumCores; c++) begin : g_core
        irm_core_tracker #(
            .DWidth(DWidth), .ExitReg(ExitReg), .ImgReg(ImgReg),
            .CorrReg(CorrReg), .ExitCode(ExitCode)
        ) u_trk (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .clr_i      (clr),
            .active_i   (run),
            .wb_valid_i (wb_valid_i[c]),
            .wb_rd_i    (wb_rd_i[c*REG_IDX_W +: REG_IDX_W]),
            .wb_data_i  (wb_data_i[c*DWidth +: DWidth]),
            .corr_o     (corr[c]),
            .exit_o     (exit_q[c]),
            .exit_set_o (exit_set[c]),
            .img_evt_o  (evt[c])
        );
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: the last exit takes priority over a coincident timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (&(exit_q | exit_set))
                    state_d = DONE;
                else if (TimeoutCycles != 0 && cycle_q == 64'(TimeoutCycles - 1))
                    state_d = TIMEOUT;
            end
            default: if (start_i) state_d = RUN;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy_o    = (state_q == RUN);
        done_o    = (state_q == DONE);
        timeout_o = (state_q == TIMEOUT);
    end

    // Sum of correct shadows and number of image events this cycle.
    always_comb begin
        corr_sum = '0;
        n_evt    = '0;
        for (int c = 0; c < NumCores; c++) begin
            corr_sum = corr_sum + corr[c];
            n_evt    = n_evt + {3'b0, evt[c]};
        end
        img_sum = {1'b0, image_tot_q} + (DWidth+1)'(n_evt);
    end

    // Aggregate counters; image total and cycle count saturate.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr) begin
            correct_tot_q <= '0;
            image_tot_q   <= '0;
            cycle_q       <= '0;
        end else begin
            correct_tot_q <= corr_sum;
            image_tot_q   <= img_sum[DWidth] ? '1 : img_sum[DWidth-1:0];
            if (run && cycle_q != '1) cycle_q <= cycle_q + 64'd1;
        end
    end

    assign core_exit_o   = exit_q;
    assign correct_tot_o = correct_tot_q;
    assign image_tot_o   = image_tot_q;
    assign cycle_o       = cycle_q;

`ifdef LAT_FIFO_EN
    localparam int PW = $clog2(LatDepth);

    logic [NumCores-1:0][63:0]     stamp_q;
    logic [DWidth-1:0]             mem_q [LatDepth];
    logic [PW-1:0]                 wr_q, rd_q, wr_d;
    logic [PW:0]                   cnt_q, cnt_d;
    logic                          ovf_q, ovf_set, pop;
    logic [NumCores-1:0]           push_en;
    logic [NumCores-1:0][PW-1:0]   push_idx;
    logic [NumCores-1:0][DWidth-1:0] entry;
    logic [63:0]                   lat;

    assign pop = (cnt_q != '0) && lat_ready_i;

    // Allocate FIFO slots to this cycle's events in ascending core order.
    always_comb begin
        int n;
        int free;
        n        = 0;
        free     = LatDepth - int'(cnt_q) + (pop ? 1 : 0);
        ovf_set  = 1'b0;
        push_en  = '0;
        push_idx = '0;
        entry    = '0;
        lat      = '0;
        for (int c = 0; c < NumCores; c++) begin
            lat      = cycle_q - stamp_q[c];
            entry[c] = {LAT_CORE_W'(c), lat[DWidth-4:0]};
            push_idx[c] = wr_q + n[PW-1:0];
            if (evt[c]) begin
                if (n < free) begin
                    push_en[c] = 1'b1;
                    n = n + 1;
                end else begin
                    ovf_set = 1'b1;
                end
            end
        end
        wr_d  = wr_q + n[PW-1:0];
        cnt_d = cnt_q + n[PW:0] - {{PW{1'b0}}, pop};
    end

    // FIFO pointers, overflow flag and per-core timestamps.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            stamp_q <= '0;
        end else begin
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            if (pop) rd_q <= rd_q + PW'(1);
            if (ovf_set) ovf_q <= 1'b1;
            for (int c = 0; c < NumCores; c++)
                if (evt[c]) stamp_q[c] <= cycle_q;
        end
    end

    // FIFO storage; stale contents are masked by the valid count.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NumCores; c++)
            if (push_en[c]) mem_q[push_idx[c]] <= entry[c];
    end

    assign lat_valid_o = (cnt_q != '0);
    assign lat_data_o  = lat_valid_o ? mem_q[rd_q] : '0;
    assign lat_ovf_o   = ovf_q;
`else
    logic unused_lat_ready;
    assign unused_lat_ready = lat_ready_i;
    assign lat_valid_o = 1'b0;
    assign lat_data_o  = '0;
    assign lat_ovf_o   = 1'b0;
`endif

endmodule

// File: tb/tb_inference_run_monitor.sv
// Directed bench for inference_run_monitor: 2 cores, TimeoutCycles=100, LatDepth=4.
module tb_inference_run_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  wb_valid = '0;
    logic [9:0]  wb_rd = '0;
    logic [63:0] wb_data = '0;
    logic        lat_ready = 1'b0;
    logic        busy, done, timeout, lat_valid, lat_ovf;
    logic [1:0]  core_exit;
    logic [31:0] correct_tot, image_tot, lat_data;
    logic [63:0] cycle;

    int chk_cnt = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    inference_run_monitor #(
        .DWidth(32), .NumCores(2), .NumOfTest(10), .ExitReg(25), .ImgReg(26),
        .CorrReg(27), .ExitCode(99999), .TimeoutCycles(100), .LatDepth(4)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .busy_o(busy), .done_o(done), .timeout_o(timeout),
        .core_exit_o(core_exit), .correct_tot_o(correct_tot), .image_tot_o(image_tot),
        .cycle_o(cycle), .lat_valid_o(lat_valid), .lat_data_o(lat_data),
        .lat_ready_i(lat_ready), .lat_ovf_o(lat_ovf)
    );

    task automatic drive(input int c, input logic [4:0] rd, input logic [31:0] d);
        wb_valid[c]         = 1'b1;
        wb_rd[c*5 +: 5]     = rd;
        wb_data[c*32 +: 32] = d;
    endtask

    task automatic step();
        @(negedge clk);
        wb_valid  = '0;
        start     = 1'b0;
        lat_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; step(); step(); rst = 1'b0;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (done !== 1'b0 || timeout !== 1'b0) $display("FAIL reset_flags got %b%b want 00", done, timeout); else pass_cnt++;
        chk_cnt++; if (image_tot !== 0 || correct_tot !== 0 || cycle !== 0) $display("FAIL reset_cnt got %0d %0d %0d want 0", image_tot, correct_tot, cycle); else pass_cnt++;
        chk_cnt++; if (core_exit !== 2'b00) $display("FAIL reset_exit got %b want 00", core_exit); else pass_cnt++;
    endtask

    task automatic test_single();
        start = 1'b1; step();
        chk_cnt++; if (busy !== 1'b1 || cycle !== 0) $display("FAIL single_start got busy=%b cyc=%0d want 1 0", busy, cycle); else pass_cnt++;
        for (int i = 1; i <= 10; i++) begin drive(0, 5'd26, i); step(); end
        chk_cnt++; if (image_tot !== 10) $display("FAIL single_img got %0d want 10", image_tot); else pass_cnt++;
        drive(0, 5'd27, 9); step(); step();
        chk_cnt++; if (correct_tot !== 9) $display("FAIL single_corr got %0d want 9", correct_tot); else pass_cnt++;
        drive(0, 5'd25, 99999); step();
        chk_cnt++; if (core_exit !== 2'b01 || done !== 1'b0 || busy !== 1'b1) $display("FAIL single_exit0 got %b %b %b want 01 0 1", core_exit, done, busy); else pass_cnt++;
        drive(1, 5'd25, 99999); step();
        chk_cnt++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL single_done got %b %b want 1 0", done, busy); else pass_cnt++;
        chk_cnt++; if (cycle !== 14) $display("FAIL single_cycle got %0d want 14", cycle); else pass_cnt++;
        step();
        chk_cnt++; if (cycle !== 14 || done !== 1'b1) $display("FAIL single_hold got %0d %b want 14 1", cycle, done); else pass_cnt++;
    endtask

    task automatic test_two_core();
        start = 1'b1; step();
        chk_cnt++; if (done !== 1'b0 || busy !== 1'b1 || correct_tot !== 0) $display("FAIL two_restart got %b %b %0d want 0 1 0", done, busy, correct_tot); else pass_cnt++;
        for (int i = 1; i <= 10; i++) begin drive(0, 5'd26, i); drive(1, 5'd26, i); step(); end
        chk_cnt++; if (image_tot !== 20) $display("FAIL two_img got %0d want 20", image_tot); else pass_cnt++;
        drive(0, 5'd25, 99999); step();
        chk_cnt++; if (done !== 1'b0 || core_exit !== 2'b01) $display("FAIL two_first_exit got %b %b want 0 01", done, core_exit); else pass_cnt++;
        drive(1, 5'd25, 99999); step();
        chk_cnt++; if (done !== 1'b1 || core_exit !== 2'b11) $display("FAIL two_done got %b %b want 1 11", done, core_exit); else pass_cnt++;
    endtask

    task automatic test_rewrite();
        drive(0, 5'd26, 11); step();
        chk_cnt++; if (image_tot !== 20) $display("FAIL rw_done_write got %0d want 20", image_tot); else pass_cnt++;
        start = 1'b1; step();
        chk_cnt++; if (image_tot !== 0) $display("FAIL rw_clear got %0d want 0", image_tot); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin drive(0, 5'd26, 3); step(); end
        chk_cnt++; if (image_tot !== 1) $display("FAIL rw_same got %0d want 1", image_tot); else pass_cnt++;
        drive(0, 5'd26, 0); step();
        chk_cnt++; if (image_tot !== 1) $display("FAIL rw_zero got %0d want 1", image_tot); else pass_cnt++;
        drive(0, 5'd26, 3); step();
        chk_cnt++; if (image_tot !== 2) $display("FAIL rw_back got %0d want 2", image_tot); else pass_cnt++;
        drive(0, 5'd25, 12345); step();
        chk_cnt++; if (core_exit !== 2'b00) $display("FAIL rw_badcode got %b want 00", core_exit); else pass_cnt++;
        drive(0, 5'd25, 99999); step();
        drive(0, 5'd26, 7); step();
        chk_cnt++; if (image_tot !== 2 || core_exit !== 2'b01) $display("FAIL rw_after_exit got %0d %b want 2 01", image_tot, core_exit); else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        for (int i = 1; i <= 5; i++) begin drive(1, 5'd26, i); step(); end
        chk_cnt++; if (image_tot !== 7 || busy !== 1'b1) $display("FAIL mr_pre got %0d %b want 7 1", image_tot, busy); else pass_cnt++;
        rst = 1'b1; step(); rst = 1'b0;
        chk_cnt++; if ({busy, done, timeout} !== 3'b000 || core_exit !== 2'b00) $display("FAIL mr_flags got %b%b%b %b want 000 00", busy, done, timeout, core_exit); else pass_cnt++;
        chk_cnt++; if (image_tot !== 0 || correct_tot !== 0 || cycle !== 0) $display("FAIL mr_cnt got %0d %0d %0d want 0", image_tot, correct_tot, cycle); else pass_cnt++;
        drive(1, 5'd26, 9); step();
        chk_cnt++; if (image_tot !== 0 || busy !== 1'b0) $display("FAIL mr_idle_write got %0d %b want 0 0", image_tot, busy); else pass_cnt++;
        start = 1'b1; step();
        drive(0, 5'd26, 1); step();
        chk_cnt++; if (image_tot !== 1 || core_exit !== 2'b00 || cycle !== 1) $display("FAIL mr_resume got %0d %b %0d want 1 00 1", image_tot, core_exit, cycle); else pass_cnt++;
    endtask

    task automatic test_timeout();
        rst = 1'b1; step(); rst = 1'b0;
        start = 1'b1; step();
        repeat (99) step();
        chk_cnt++; if (cycle !== 99 || timeout !== 1'b0 || busy !== 1'b1) $display("FAIL to_pre got %0d %b %b want 99 0 1", cycle, timeout, busy); else pass_cnt++;
        step();
        chk_cnt++; if (timeout !== 1'b1 || cycle !== 100 || busy !== 1'b0 || done !== 1'b0) $display("FAIL to_hit got %b %0d %b %b want 1 100 0 0", timeout, cycle, busy, done); else pass_cnt++;
        step();
        chk_cnt++; if (cycle !== 100 || timeout !== 1'b1) $display("FAIL to_hold got %0d %b want 100 1", cycle, timeout); else pass_cnt++;
    endtask

    task automatic test_tie();
        start = 1'b1; step();
        chk_cnt++; if (busy !== 1'b1 || timeout !== 1'b0 || cycle !== 0) $display("FAIL tie_restart got %b %b %0d want 1 0 0", busy, timeout, cycle); else pass_cnt++;
        repeat (99) step();
        drive(0, 5'd25, 99999); drive(1, 5'd25, 99999); step();
        chk_cnt++; if (done !== 1'b1 || timeout !== 1'b0) $display("FAIL tie_done_wins got %b %b want 1 0", done, timeout); else pass_cnt++;
    endtask

    task automatic test_lat();
        logic [31:0] exp_lat [4];
        rst = 1'b1; step(); rst = 1'b0;
        start = 1'b1; step();
`ifdef LAT_FIFO_EN
        exp_lat[0] = 32'h0000_0000;
        exp_lat[1] = 32'h0000_0003;
        exp_lat[2] = 32'h0000_0002;
        exp_lat[3] = 32'h2000_0005;
        drive(0, 5'd26, 1); step();
        step(); step();
        drive(0, 5'd26, 2); step();
        step();
        drive(0, 5'd26, 3); drive(1, 5'd26, 1); step();
        drive(0, 5'd26, 4); step();
        drive(1, 5'd26, 2); step();
        chk_cnt++; if (lat_valid !== 1'b1 || lat_ovf !== 1'b1) $display("FAIL lat_full got %b %b want 1 1", lat_valid, lat_ovf); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            chk_cnt++; if (lat_data !== exp_lat[i]) $display("FAIL lat_pop%0d got %h want %h", i, lat_data, exp_lat[i]); else pass_cnt++;
            lat_ready = 1'b1; step();
        end
        chk_cnt++; if (lat_valid !== 1'b0 || lat_ovf !== 1'b1) $display("FAIL lat_empty got %b %b want 0 1", lat_valid, lat_ovf); else pass_cnt++;
`else
        exp_lat[0] = 32'h0;
        drive(0, 5'd26, 1); drive(1, 5'd26, 1); step();
        lat_ready = 1'b1; step();
        chk_cnt++; if (lat_valid !== 1'b0 || lat_ovf !== 1'b0 || lat_data !== exp_lat[0]) $display("FAIL lat_tied got %b %b %h want 0 0 0", lat_valid, lat_ovf, lat_data); else pass_cnt++;
        chk_cnt++; if (image_tot !== 2) $display("FAIL lat_img got %0d want 2", image_tot); else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_core();
        test_rewrite();
        test_mid_reset();
        test_timeout();
        test_tie();
        test_lat();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
